spot_ram_writer: RTL

Writer side of the spot finder block RAM. It accepts the camera's 8-bit pixel stream, packs 32 consecutive pixels into one 256-bit kernel word, and writes the words to consecutive addresses from 0. After a complete frame is in RAM it releases the spot finder from reset. It then waits for the spot finder's analysis-ready pulse before accepting the next frame, so the analysis never reads a partially written image.

---
 rtl/spot_ram_writer.sv | 116 +++++++++++
 1 files changed

// File: rtl/spot_ram_writer.sv
// Packs the 8-bit camera pixel stream into 256-bit kernel words and writes them to the
// spot finder BRAM. The spot finder is held in reset until a whole frame is in RAM.
module spot_ram_writer #(
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [7:0]            pixel_data,
    input  logic                  pixel_valid,
    input  logic                  frame_start,
    input  logic [15:0]           cam_kernels_x,
    input  logic [15:0]           cam_lines_y,
    input  logic                  analysis_rdy,
    output logic                  wr_en,
    output logic [13:0]           wr_address,
    output logic [255:0]          wr_data,
    output logic                  spot_finder_reset,
    output logic                  frame_rdy,
    output logic                  config_err,
    output logic [DROP_CNT_W-1:0] dropped_frames
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t       state, state_nxt;
    logic [14:0]  total;        // 15 bits so that 16384 itself is representable
    logic [14:0]  word_cnt;
    logic [5:0]   pixel_idx;
    logic [255:0] pack;
    logic [31:0]  product;
    logic         dims_ok;
    logic         frame_req;
    logic         start_frame;
    logic         take_pixel;
    logic         word_done;
    logic         drop_inc;

    always_comb begin
        product     = 32'(cam_kernels_x) * 32'(cam_lines_y);
        dims_ok     = (product != 32'd0) && (product <= 32'd16384);
        frame_req   = frame_start && (state != DONE);
        state_nxt   = state;
        start_frame = 1'b0;
        take_pixel  = 1'b0;
        drop_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    start_frame = dims_ok;
                    if (dims_ok) state_nxt = FILL;
                end
            end
            FILL: begin
                // A new frame_start always wins, even in the cycle the last word is written.
                if (frame_start) begin
                    start_frame = dims_ok;
                    state_nxt   = dims_ok ? FILL : IDLE;
                end else if (word_cnt == total) begin
                    state_nxt = DONE;
                end else begin
                    take_pixel = pixel_valid;
                end
            end
            DONE: begin
                drop_inc = frame_start;
                if (analysis_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        word_done = take_pixel && (pixel_idx == 6'd31);
    end

    always_ff @(posedge clk_in) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            total          <= '0;
            word_cnt       <= '0;
            pixel_idx      <= '0;
            pack           <= '0;
            wr_en          <= 1'b0;
            wr_address     <= '0;
            wr_data        <= '0;
            config_err     <= 1'b0;
            dropped_frames <= '0;
        end else begin
            wr_en <= word_done;
            if (frame_req) config_err <= !dims_ok;
            if (start_frame) begin
                total     <= product[14:0];
                word_cnt  <= '0;
                pixel_idx <= pixel_valid ? 6'd1 : 6'd0;
                if (pixel_valid) pack[7:0] <= pixel_data;
            end else if (take_pixel) begin
                pack[{pixel_idx[4:0], 3'b000} +: 8] <= pixel_data;
                if (word_done) begin
                    wr_data    <= {pixel_data, pack[247:0]};
                    wr_address <= word_cnt[13:0];
                    word_cnt   <= word_cnt + 15'd1;
                    pixel_idx  <= '0;
                end else begin
                    pixel_idx <= pixel_idx + 6'd1;
                end
            end
            if (drop_inc && (dropped_frames != '1))
                dropped_frames <= dropped_frames + DROP_CNT_W'(1);
        end
    end

    assign frame_rdy         = (state == DONE);
    assign spot_finder_reset = (state != DONE);

endmodule
